// File: rtl/bus_pkg.sv
// Shared serial-bus constants and types used by the initiator port and its serializer.
package bus_pkg;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 5;

    localparam logic MODE_ADDR = 1'b0;
    localparam logic MODE_DATA = 1'b1;

    localparam logic [CNT_W-1:0] LEN_ADDR = 5'd16;
    localparam logic [CNT_W-1:0] LEN_DATA = 5'd8;

    typedef enum logic {
        TX_IDLE,
        TX_SHIFT
    } tx_state_e;
endpackage

// File: rtl/piso_serializer.sv
// Parallel-in, serial-out shifter: emits load_len_i bits of load_data_i LSB first,
// accepting a new load while idle or during the final bit of the current frame.
module piso_serializer
    import bus_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] load_data_i,
    input  logic [CNT_W-1:0]  load_len_i,
    output logic              bit_o,
    output logic              valid_o
);

    tx_state_e         state_q, state_d;
    logic [ADDR_W-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              can_load;

    // Reloading on the last-bit cycle lets frames run back to back with no idle gap.
    assign can_load = (state_q == TX_IDLE) || (cnt_q == 5'd1);

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        case (state_q)
            TX_IDLE: ;
            TX_SHIFT: begin
                shreg_d = {1'b0, shreg_q[ADDR_W-1:1]};
                cnt_d   = cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    state_d = TX_IDLE;
                end
            end
            default: state_d = TX_IDLE;
        endcase
        if (load_i && can_load) begin
            shreg_d = load_data_i;
            cnt_d   = load_len_i;
            state_d = TX_SHIFT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= TX_IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

    // Upper bits are zero-filled while shifting, so the line rests at 0 when idle.
    assign bit_o   = shreg_q[0];
    assign valid_o = (state_q == TX_SHIFT);

endmodule

// File: rtl/init_port.sv
// Initiator-side bus port: serializes address/write bytes onto the bus, assembles
// LSB-first read bytes, and forwards arbitration and handshake signals.
module init_port
    import bus_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              init_req,
    input  logic              arbiter_grant,
    input  logic [DATA_W-1:0] init_data_out,
    input  logic              init_data_out_valid,
    input  logic [ADDR_W-1:0] init_addr_out,
    input  logic              init_addr_out_valid,
    input  logic              init_rw,
    input  logic              init_ready,
    input  logic              init_bus_mode,
    input  logic              target_split,
    input  logic              target_ack,
    input  logic              bus_data_in_valid,
    input  logic              bus_data_in,
    output logic              bus_data_out,
    output logic              init_grant,
    output logic [DATA_W-1:0] init_data_in,
    output logic              init_data_in_valid,
    output logic              bus_data_out_valid,
    output logic              arbiter_req,
    output logic              bus_mode,
    output logic              init_ack,
    output logic              bus_init_ready,
    output logic              bus_init_rw,
    output logic              init_split_ack
);

    assign init_grant     = arbiter_grant;
    assign arbiter_req    = init_req;
    assign bus_mode       = init_bus_mode;
    assign init_ack       = target_ack;
    assign bus_init_ready = init_ready;
    assign bus_init_rw    = init_rw;
    assign init_split_ack = target_split;

    logic              addr_ld;
    logic              data_ld;
    logic [ADDR_W-1:0] tx_word;
    logic [CNT_W-1:0]  tx_len;

    // Address wins when both strobes qualify in the same cycle.
    assign addr_ld = init_addr_out_valid && (init_bus_mode == MODE_ADDR);
    assign data_ld = init_data_out_valid && (init_bus_mode == MODE_DATA) && init_rw;
    assign tx_word = addr_ld ? init_addr_out : {{(ADDR_W-DATA_W){1'b0}}, init_data_out};
    assign tx_len  = addr_ld ? LEN_ADDR : LEN_DATA;

    piso_serializer u_piso (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (addr_ld || data_ld),
        .load_data_i (tx_word),
        .load_len_i  (tx_len),
        .bit_o       (bus_data_out),
        .valid_o     (bus_data_out_valid)
    );

    logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
    logic [2:0]        rx_cnt_q, rx_cnt_d;
    logic [DATA_W-1:0] rx_byte_q, rx_byte_d;
    logic              rx_vld_q, rx_vld_d;

    // Bits enter at the MSB so the first bit received ends up in bit 0.
    always_comb begin
        rx_sh_d   = rx_sh_q;
        rx_cnt_d  = rx_cnt_q;
        rx_byte_d = rx_byte_q;
        rx_vld_d  = 1'b0;
        if (bus_data_in_valid) begin
            rx_sh_d  = {bus_data_in, rx_sh_q[DATA_W-1:1]};
            rx_cnt_d = rx_cnt_q + 3'd1;
            if (rx_cnt_q == 3'd7) begin
                rx_byte_d = {bus_data_in, rx_sh_q[DATA_W-1:1]};
                rx_vld_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_sh_q   <= '0;
            rx_cnt_q  <= '0;
            rx_byte_q <= '0;
            rx_vld_q  <= 1'b0;
        end else begin
            rx_sh_q   <= rx_sh_d;
            rx_cnt_q  <= rx_cnt_d;
            rx_byte_q <= rx_byte_d;
            rx_vld_q  <= rx_vld_d;
        end
    end

    assign init_data_in       = rx_byte_q;
    assign init_data_in_valid = rx_vld_q;

endmodule

// File: tb/tb_init_port.sv
// Directed bench for init_port: table-driven pass-through and TX-load vectors,
// plus hand-written back-to-back, busy-strobe, reset and RX sequences.
module tb_init_port;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        init_req, arbiter_grant;
    logic [7:0]  init_data_out;
    logic        init_data_out_valid;
    logic [15:0] init_addr_out;
    logic        init_addr_out_valid;
    logic        init_rw, init_ready, init_bus_mode;
    logic        target_split, target_ack;
    logic        bus_data_in_valid, bus_data_in;
    logic        bus_data_out, init_grant;
    logic [7:0]  init_data_in;
    logic        init_data_in_valid, bus_data_out_valid;
    logic        arbiter_req, bus_mode, init_ack, bus_init_ready, bus_init_rw, init_split_ack;

    int total = 0;
    int bad   = 0;
    int pulses = 0;

    always #5 clk = ~clk;

    always @(negedge clk) if (init_data_in_valid) pulses++;

    init_port dut (
        .clk(clk), .rst_n(rst_n), .init_req(init_req), .arbiter_grant(arbiter_grant),
        .init_data_out(init_data_out), .init_data_out_valid(init_data_out_valid),
        .init_addr_out(init_addr_out), .init_addr_out_valid(init_addr_out_valid),
        .init_rw(init_rw), .init_ready(init_ready), .init_bus_mode(init_bus_mode),
        .target_split(target_split), .target_ack(target_ack),
        .bus_data_in_valid(bus_data_in_valid), .bus_data_in(bus_data_in),
        .bus_data_out(bus_data_out), .init_grant(init_grant),
        .init_data_in(init_data_in), .init_data_in_valid(init_data_in_valid),
        .bus_data_out_valid(bus_data_out_valid), .arbiter_req(arbiter_req),
        .bus_mode(bus_mode), .init_ack(init_ack), .bus_init_ready(bus_init_ready),
        .bus_init_rw(bus_init_rw), .init_split_ack(init_split_ack)
    );

    typedef struct {
        logic [6:0] in;   // {arbiter_grant, init_req, init_bus_mode, target_ack, target_split, init_ready, init_rw}
        logic [6:0] exp;  // {init_grant, arbiter_req, bus_mode, init_ack, init_split_ack, bus_init_ready, bus_init_rw}
    } pt_vec_t;

    typedef struct {
        logic        mode, rw, av, dv;
        logic [15:0] addr;
        logic [7:0]  data;
        int          exp_len;
        logic [15:0] exp_val;
    } tx_vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic capture(output int n, output logic [15:0] v);
        n = 0;
        v = '0;
        while (bus_data_out_valid && n < 24) begin
            if (n < 16) v[n] = bus_data_out;
            n++;
            step();
        end
    endtask

    task automatic rx_byte(input logic [7:0] b, input int gap, input string name);
        int p0;
        p0 = pulses;
        for (int i = 0; i < 8; i++) begin
            bus_data_in_valid = 1'b1;
            bus_data_in       = b[i];
            step();
            bus_data_in_valid = 1'b0;
            bus_data_in       = 1'b0;
            if (i < 7) repeat ((i % 3) * gap) step();
        end
        check({name, "_vld"}, {31'd0, init_data_in_valid}, 32'd1);
        check({name, "_byte"}, {24'd0, init_data_in}, {24'd0, b});
        step();
        check({name, "_vld_drop"}, {31'd0, init_data_in_valid}, 32'd0);
        check({name, "_pulses"}, pulses - p0, 32'd1);
    endtask

    pt_vec_t pt_tab[6];
    tx_vec_t tx_tab[6];

    initial begin
        int          n;
        logic [15:0] v;
        logic [7:0]  v8;

        pt_tab[0] = '{7'b0000000, 7'b0000000};
        pt_tab[1] = '{7'b1000000, 7'b1000000};
        pt_tab[2] = '{7'b0101010, 7'b0101010};
        pt_tab[3] = '{7'b0011000, 7'b0011000};
        pt_tab[4] = '{7'b1010101, 7'b1010101};
        pt_tab[5] = '{7'b1111111, 7'b1111111};

        //            mode  rw    av    dv    addr      data   len val
        tx_tab[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'hA55A, 8'h00, 16, 16'hA55A};
        tx_tab[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 16'h0000, 8'h3C, 8,  16'h003C};
        tx_tab[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 8'hC3, 0,  16'h0000};
        tx_tab[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 16'h8001, 8'hFF, 16, 16'h8001};
        tx_tab[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 16'hFFFF, 8'h00, 0,  16'h0000};
        tx_tab[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 16'hFFFF, 8'hE7, 8,  16'h00E7};

        rst_n = 1'b0;
        {init_req, arbiter_grant, init_data_out_valid, init_addr_out_valid} = '0;
        {init_rw, init_ready, init_bus_mode, target_split, target_ack} = '0;
        {bus_data_in_valid, bus_data_in} = '0;
        init_data_out = '0;
        init_addr_out = '0;
        step();
        step();
        check("rst_outs", {28'd0, bus_data_out, bus_data_out_valid, init_data_in_valid, |init_data_in}, 32'd0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 6; i++) begin
            {arbiter_grant, init_req, init_bus_mode, target_ack, target_split, init_ready, init_rw} = pt_tab[i].in;
            #1;
            check($sformatf("passthru%0d", i),
                  {25'd0, init_grant, arbiter_req, bus_mode, init_ack, init_split_ack, bus_init_ready, bus_init_rw},
                  {25'd0, pt_tab[i].exp});
        end
        {arbiter_grant, init_req, init_bus_mode, target_ack, target_split, init_ready, init_rw} = '0;
        step();

        for (int i = 0; i < 6; i++) begin
            init_bus_mode       = tx_tab[i].mode;
            init_rw             = tx_tab[i].rw;
            init_addr_out_valid = tx_tab[i].av;
            init_data_out_valid = tx_tab[i].dv;
            init_addr_out       = tx_tab[i].addr;
            init_data_out       = tx_tab[i].data;
            step();
            init_addr_out_valid = 1'b0;
            init_data_out_valid = 1'b0;
            capture(n, v);
            check($sformatf("tx%0d_len", i), n, tx_tab[i].exp_len);
            check($sformatf("tx%0d_val", i), {16'd0, v}, {16'd0, tx_tab[i].exp_val});
            step();
            check($sformatf("tx%0d_idle", i), {31'd0, bus_data_out_valid}, 32'd0);
        end

        // Back-to-back: an address load on the last data bit starts the next frame at once.
        init_bus_mode = 1'b1; init_rw = 1'b1;
        init_data_out = 8'h3C; init_data_out_valid = 1'b1;
        step();
        init_data_out_valid = 1'b0;
        v8 = '0;
        for (int k = 0; k < 8; k++) begin
            check($sformatf("b2b_vld%0d", k), {31'd0, bus_data_out_valid}, 32'd1);
            v8[k] = bus_data_out;
            if (k == 7) begin
                init_bus_mode = 1'b0;
                init_addr_out = 16'h1234;
                init_addr_out_valid = 1'b1;
            end
            step();
        end
        init_addr_out_valid = 1'b0;
        check("b2b_data", {24'd0, v8}, 32'h3C);
        capture(n, v);
        check("b2b_addr_len", n, 16);
        check("b2b_addr_val", {16'd0, v}, 32'h1234);

        // Strobes while busy must not disturb the running frame.
        init_bus_mode = 1'b0;
        init_addr_out = 16'hA55A; init_addr_out_valid = 1'b1;
        step();
        init_addr_out_valid = 1'b0;
        n = 0; v = '0;
        while (bus_data_out_valid && n < 24) begin
            if (n < 16) v[n] = bus_data_out;
            n++;
            init_addr_out_valid = (n == 3);
            init_addr_out       = (n == 3) ? 16'hFFFF : 16'hA55A;
            init_bus_mode       = (n == 6);
            init_rw             = 1'b1;
            init_data_out       = 8'hFF;
            init_data_out_valid = (n == 6);
            step();
        end
        init_addr_out_valid = 1'b0; init_data_out_valid = 1'b0; init_bus_mode = 1'b0;
        check("busy_len", n, 16);
        check("busy_val", {16'd0, v}, 32'hA55A);

        rx_byte(8'h96, 0, "rx96");
        rx_byte(8'h5A, 1, "rx5A_gaps");

        // Mid-frame reset aborts TX and discards partial RX bits.
        init_addr_out = 16'hFFFF; init_addr_out_valid = 1'b1;
        bus_data_in_valid = 1'b1; bus_data_in = 1'b1;
        step();
        init_addr_out_valid = 1'b0;
        repeat (3) step();
        bus_data_in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_mid_vld", {31'd0, bus_data_out_valid}, 32'd0);
        check("rst_mid_bit", {31'd0, bus_data_out}, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        step();
        check("rst_after_vld", {30'd0, bus_data_out_valid, bus_data_out}, 32'd0);
        rx_byte(8'h0F, 0, "rx_after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
